// File: rtl/tis_exec_core.sv
// tis_exec_core: single-issue TIS-100-style execution node.
// Runs one instruction per clock from a small program array.
module tis_exec_core #(
    parameter int NUM_INSTR = 15,
    parameter int VAL_MAX   = 999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  pLength,
    input  logic [15:0] prog [0:NUM_INSTR-1],
    output logic [3:0]  pc,
    output logic [10:0] acc,
    output logic [10:0] bak
);

    localparam logic signed [12:0] VMAX = 13'(VAL_MAX);
    localparam logic signed [12:0] VMIN = -13'(VAL_MAX);

    localparam logic [3:0] OP_MOV = 4'h1;
    localparam logic [3:0] OP_SWP = 4'h2;
    localparam logic [3:0] OP_SAV = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_SUB = 4'h5;
    localparam logic [3:0] OP_NEG = 4'h6;
    localparam logic [3:0] OP_JMP = 4'h7;
    localparam logic [3:0] OP_JEZ = 4'h8;
    localparam logic [3:0] OP_JNZ = 4'h9;
    localparam logic [3:0] OP_JGZ = 4'hA;
    localparam logic [3:0] OP_JLZ = 4'hB;
    localparam logic [3:0] OP_JRO = 4'hC;

    function automatic logic signed [12:0] clamp13(
        input logic signed [12:0] v
    );
        if (v > VMAX)
            return VMAX;
        else if (v < VMIN)
            return VMIN;
        else
            return v;
    endfunction

    logic [15:0]        instr;
    logic [3:0]         op;
    logic               src_sel;
    logic [10:0]        imm;
    logic signed [12:0] imm_ext;
    logic signed [12:0] acc_ext;
    logic signed [12:0] src_val;
    logic signed [12:0] add_res;
    logic signed [12:0] sub_res;
    logic signed [12:0] neg_res;
    logic signed [12:0] jro_sum;
    logic signed [12:0] plen_m1;
    logic [4:0]         pc_inc;
    logic [3:0]         pc_seq;
    logic [3:0]         pc_jmp;
    logic [3:0]         pc_jro;
    logic [3:0]         tgt;
    logic [3:0]         pc_nxt;
    logic [10:0]        acc_nxt;
    logic [10:0]        bak_nxt;

    // Fetch and decode operand fields; a pc past the array reads as NOP.
    always_comb begin
        instr = 16'h0000;
        if (32'(pc) < NUM_INSTR)
            instr = prog[pc];
    end

    assign op      = instr[15:12];
    assign src_sel = instr[11];
    assign imm     = instr[10:0];
    assign tgt     = imm[3:0];

    assign imm_ext = {{2{imm[10]}}, imm};
    assign acc_ext = {{2{acc[10]}}, acc};
    assign src_val = src_sel ? acc_ext : clamp13(imm_ext);

    assign add_res = clamp13(acc_ext + src_val);
    assign sub_res = clamp13(acc_ext - src_val);
    assign neg_res = clamp13(-acc_ext);

    // Sequential pc with wrap at the end of the valid program.
    assign pc_inc = {1'b0, pc} + 5'd1;
    assign pc_seq = (pc_inc >= {1'b0, pLength}) ? 4'd0 : pc_inc[3:0];

    // Absolute jumps outside the valid program restart at 0.
    assign pc_jmp = (tgt >= pLength) ? 4'd0 : tgt;

    // Relative jump clamped into [0, pLength-1].
    assign jro_sum = $signed({9'b0, pc}) + src_val;
    assign plen_m1 = $signed({9'b0, pLength}) - 13'sd1;

    // Clamp the relative jump result.
    always_comb begin
        pc_jro = jro_sum[3:0];
        if (jro_sum < 13'sd0)
            pc_jro = 4'd0;
        else if (jro_sum > plen_m1)
            pc_jro = plen_m1[3:0];
    end

    // Next-state selection for pc, acc and bak.
    always_comb begin
        pc_nxt  = pc_seq;
        acc_nxt = acc;
        bak_nxt = bak;
        if (pc >= pLength) begin
            pc_nxt = 4'd0;
        end else begin
            case (op)
                OP_MOV: acc_nxt = src_val[10:0];
                OP_SWP: begin
                    acc_nxt = bak;
                    bak_nxt = acc;
                end
                OP_SAV: bak_nxt = acc;
                OP_ADD: acc_nxt = add_res[10:0];
                OP_SUB: acc_nxt = sub_res[10:0];
                OP_NEG: acc_nxt = neg_res[10:0];
                OP_JMP: pc_nxt = pc_jmp;
                OP_JEZ: begin
                    if (acc_ext == 13'sd0)
                        pc_nxt = pc_jmp;
                end
                OP_JNZ: begin
                    if (acc_ext != 13'sd0)
                        pc_nxt = pc_jmp;
                end
                OP_JGZ: begin
                    if (acc_ext > 13'sd0)
                        pc_nxt = pc_jmp;
                end
                OP_JLZ: begin
                    if (acc_ext < 13'sd0)
                        pc_nxt = pc_jmp;
                end
                OP_JRO: pc_nxt = pc_jro;
                default: ;
            endcase
        end
    end

    // Architectural state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc  <= 4'd0;
            acc <= 11'd0;
            bak <= 11'd0;
        end else begin
            pc  <= pc_nxt;
            acc <= acc_nxt;
            bak <= bak_nxt;
        end
    end

endmodule

// File: tb/tb_tis_exec_core.sv
// tb_tis_exec_core: directed self-checking bench.
// Hand-computed vectors for sequencing, saturation, branches.
module tb_tis_exec_core;

    localparam logic [3:0] NOP = 4'h0;
    localparam logic [3:0] MOV = 4'h1;
    localparam logic [3:0] SWP = 4'h2;
    localparam logic [3:0] SAV = 4'h3;
    localparam logic [3:0] ADD = 4'h4;
    localparam logic [3:0] SUB = 4'h5;
    localparam logic [3:0] NEG = 4'h6;
    localparam logic [3:0] JEZ = 4'h8;
    localparam logic [3:0] JNZ = 4'h9;
    localparam logic [3:0] JGZ = 4'hA;
    localparam logic [3:0] JRO = 4'hC;

    logic        clk;
    logic        rst;
    logic [3:0]  plen;
    logic [15:0] prog [0:14];
    logic [3:0]  pc;
    logic [10:0] acc;
    logic [10:0] bak;

    int n_chk;
    int n_fail;

    tis_exec_core dut (
        .clk     (clk),
        .rst     (rst),
        .pLength (plen),
        .prog    (prog),
        .pc      (pc),
        .acc     (acc),
        .bak     (bak)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] ins(
        input logic [3:0] op,
        input int         imm
    );
        logic [31:0] v;
        v = 32'(imm);
        return {op, 1'b0, v[10:0]};
    endfunction

    task automatic check(
        input string tag,
        input int    obs,
        input int    exp
    );
        n_chk++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d",
                     tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    task automatic clr_prog();
        for (int i = 0; i < 15; i++)
            prog[i] = 16'h0000;
    endtask

    function automatic int sacc();
        return int'($signed(acc));
    endfunction

    function automatic int sbak();
        return int'($signed(bak));
    endfunction

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b1;
        plen   = 4'd4;
        for (int i = 0; i < 15; i++)
            prog[i] = 16'(i * 16'h1357 + 16'h4321);

        // reset with garbage program
        step(2);
        check("rst_pc", int'(pc), 0);
        check("rst_acc", sacc(), 0);
        check("rst_bak", sbak(), 0);

        // basic sequence
        clr_prog();
        prog[0] = ins(MOV, 5);
        prog[1] = ins(ADD, 3);
        prog[2] = ins(SAV, 0);
        prog[3] = ins(SUB, 10);
        rst = 1'b0;
        step(1);
        check("first_acc", sacc(), 5);
        check("first_pc", int'(pc), 1);
        step(3);
        check("seq_acc", sacc(), -2);
        check("seq_bak", sbak(), 8);
        check("seq_pc", int'(pc), 0);
        step(2);
        check("seq2_acc", sacc(), 8);
        check("seq2_pc", int'(pc), 2);

        // reset overrides execution mid-run
        do_reset();
        check("rst2_acc", sacc(), 0);
        check("rst2_bak", sbak(), 0);
        check("rst2_pc", int'(pc), 0);

        // saturation
        prog[0] = ins(MOV, 900);
        prog[1] = ins(ADD, 200);
        prog[2] = ins(MOV, -900);
        prog[3] = ins(SUB, 500);
        step(2);
        check("sat_hi", sacc(), 999);
        step(2);
        check("sat_lo", sacc(), -999);
        check("sat_pc", int'(pc), 0);
        prog[0] = {MOV, 1'b0, 11'h7FF};
        prog[1] = ins(MOV, 1000);
        step(1);
        check("imm_neg1", sacc(), -1);
        step(1);
        check("imm_clamp", sacc(), 999);
        check("imm_pc", int'(pc), 2);

        // branches
        do_reset();
        prog[0] = ins(JNZ, 2);
        prog[1] = ins(JEZ, 3);
        prog[2] = ins(JGZ, 7);
        prog[3] = ins(MOV, 1);
        step(1);
        check("jnz_nt", int'(pc), 1);
        step(1);
        check("jez_t", int'(pc), 3);
        step(1);
        check("mov1_acc", sacc(), 1);
        check("mov1_pc", int'(pc), 0);
        step(1);
        check("jnz_t", int'(pc), 2);
        step(1);
        check("jgz_far", int'(pc), 0);

        // SWP / NEG
        do_reset();
        clr_prog();
        plen    = 4'd5;
        prog[0] = ins(MOV, -4);
        prog[1] = ins(SAV, 0);
        prog[2] = ins(MOV, 12);
        prog[3] = ins(SWP, 0);
        prog[4] = ins(NEG, 0);
        step(3);
        check("pre_acc", sacc(), 12);
        check("pre_bak", sbak(), -4);
        step(1);
        check("swp_acc", sacc(), -4);
        check("swp_bak", sbak(), 12);
        step(1);
        check("neg_acc", sacc(), 4);
        check("neg_pc", int'(pc), 0);

        // JRO
        do_reset();
        clr_prog();
        plen    = 4'd4;
        prog[2] = ins(JRO, -5);
        step(2);
        check("jro_at2", int'(pc), 2);
        step(1);
        check("jro_neg", int'(pc), 0);
        prog[0] = ins(JRO, 20);
        prog[3] = ins(JRO, 0);
        step(1);
        check("jro_big", int'(pc), 3);
        step(1);
        check("jro_spin", int'(pc), 3);

        // pLength shrink then halt
        do_reset();
        clr_prog();
        prog[0] = ins(MOV, 7);
        prog[1] = ins(ADD, 100);
        step(1);
        check("h_acc", sacc(), 7);
        plen = 4'd1;
        step(1);
        check("shrink_pc", int'(pc), 0);
        check("shrink_acc", sacc(), 7);
        plen = 4'd0;
        step(3);
        check("halt_pc", int'(pc), 0);
        check("halt_acc", sacc(), 7);
        check("halt_bak", sbak(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/tis_exec_core.md
Name: tis_exec_core

Overview:
- Single-issue, TIS-100-style execution node: one 16-bit instruction per clock from a 15-entry program array.
- Maintains a program counter, an accumulator (ACC) and a backup register (BAK).
- Sits below the program-memory loader; pc/acc/bak are exported for debug and scoreboarding.
- No I/O ports; data-port instructions are outside this block's scope.

Parameters:
- NUM_INSTR, 15, program array depth (indices 0..14).
- VAL_MAX, 999, saturation magnitude for ACC arithmetic.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- pLength  input  4  number of valid instructions (0..15); only indices 0..pLength-1 execute.
- prog  input  15x16  unpacked program array, index 0..14; read combinationally at prog[pc].
- pc  output  4  current program counter (registered).
- acc  output  11  ACC, signed two's complement, registered.
- bak  output  11  BAK, signed two's complement, registered.

Behaviour:
- Reset: rst high at a rising edge sets pc=0, acc=0, bak=0. rst overrides any instruction executing that cycle. Outputs are held until the first edge with rst low.
- Execution model:
  - Each non-reset edge executes prog[pc] and updates pc/acc/bak together. Latency is 1 cycle per instruction.
  - pLength is sampled every cycle.
  - If pLength==0, the core halts: no state changes and pc stays 0.
- Instruction word fields:
  - [15:12] opcode.
  - [11] src: 0 = immediate, 1 = ACC.
  - [10:0] signed immediate / jump target / offset.
- Opcodes:
  - 0x0 NOP: no state change; pc advances.
  - 0x1 MOV src,ACC: acc <= sat(src).
  - 0x2 SWP: acc <= bak; bak <= acc.
  - 0x3 SAV: bak <= acc.
  - 0x4 ADD src: acc <= sat(acc + src).
  - 0x5 SUB src: acc <= sat(acc - src).
  - 0x6 NEG: acc <= -acc.
  - 0x7 JMP: unconditional jump to target [3:0].
  - 0x8 JEZ: jump if acc==0.
  - 0x9 JNZ: jump if acc!=0.
  - 0xA JGZ: jump if acc>0.
  - 0xB JLZ: jump if acc<0.
  - 0xC JRO src: pc <= clamp(pc + src, 0, pLength-1).
  - 0xD–0xF: treated as NOP.
- Saturation:
  - Arithmetic is done at 12 bits or wider, then clamped to [-999, +999].
  - An immediate outside ±999 is clamped before use.
- PC sequencing:
  - Non-jump instructions and not-taken branches: pc <= pc+1, wrapping to 0 when pc+1 >= pLength.
  - Taken jump with target >= pLength: pc <= 0.
  - If pLength changes so that pc >= pLength, the next edge forces pc <= 0 and executes nothing that cycle.
- Condition evaluation uses acc before that cycle's update.
- JRO with src=ACC uses the signed acc value; JRO 0 holds pc (spin).

Test Plan:
- Reset: assert rst 2 cycles with arbitrary program -> pc=0, acc=0, bak=0; release rst -> first instruction executes on the next edge.
- pLength=4, program [MOV 5, ADD 3, SAV, SUB 10]:
  - after 4 edges -> acc=-2, bak=8, pc=0 (wrap).
  - after a further 2 edges -> acc=8.
- Saturation:
  - MOV 900; ADD 200 -> acc=999.
  - MOV -900; SUB 500 -> acc=-999.
  - MOV with immediate 0x7FF (=-1) -> acc=-1.
- Branches, pLength=4, acc=0:
  - JEZ 3 -> pc=3.
  - JNZ 3 with acc=0 -> pc=pc+1.
  - JGZ 7 taken with pLength=4 -> pc=0.
- SWP/NEG: acc=12, bak=-4; SWP -> acc=-4, bak=12; NEG -> acc=4.
- JRO and halt:
  - JRO -5 at pc=2 -> pc=0.
  - JRO 20 -> pc=pLength-1.
  - pLength=0 for 3 cycles -> all outputs unchanged.
